spi_device_cmd_parser: RTL

//  Byte-level SPI command front end in the clk_i domain; sits upstream of spi_device_tlul_plug.

---
 rtl/spi_device_pkg.sv | 20 ++
 rtl/spi_device_byte_shreg.sv | 31 +++
 rtl/spi_device_cmd_parser.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_device_pkg.sv
// Shared types and constants for the SPI device command front end.
package spi_device_pkg;

  localparam int unsigned SpiWordBytes    = 4;
  localparam int unsigned SpiWordW        = SpiWordBytes * 8;
  localparam logic [7:0]  CmdWriteDefault = 8'h02;
  localparam logic [7:0]  CmdReadDefault  = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StIssue,
    StWpush,
    StResp,
    StRsend,
    StDone
  } cmd_state_e;

endpackage

// File: rtl/spi_device_byte_shreg.sv
// 32-bit register that shifts bytes in or out MSB-first, or loads a whole word.
module spi_device_byte_shreg
  import spi_device_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [SpiWordW-1:0] word_i,
  input  logic                shift_in_i,
  input  logic [7:0]          byte_i,
  input  logic                shift_out_i,
  output logic [SpiWordW-1:0] word_o
);

  logic [SpiWordW-1:0] word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= word_i;
    end else if (shift_in_i) begin
      word_q <= {word_q[SpiWordW-9:0], byte_i};
    end else if (shift_out_i) begin
      word_q <= {word_q[SpiWordW-9:0], 8'h00};
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/spi_device_cmd_parser.sv
// SPI command front end: parses opcode/addr/wdata bytes, drives the TL-UL plug,
// and returns read data as four bytes to the SPI serialiser.
module spi_device_cmd_parser
  import spi_device_pkg::*;
#(
  parameter logic [7:0]          CmdWrite    = CmdWriteDefault,
  parameter logic [7:0]          CmdRead     = CmdReadDefault,
  parameter int unsigned         RespTimeout = 1024,
  parameter logic [SpiWordW-1:0] TimeoutData = 32'hDEAD_BEEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                csb_i,
  input  logic [7:0]          rx_byte_i,
  input  logic                rx_byte_valid_i,
  output logic [7:0]          tx_byte_o,
  output logic                tx_byte_valid_o,
  input  logic                tx_byte_ready_i,
  output logic [SpiWordW-1:0] rxtx_addr_o,
  output logic                rxtx_addr_valid_o,
  output logic                rd_wr_o,
  output logic [SpiWordW-1:0] fifo_data_rx_o,
  output logic                fifo_data_rx_valid_o,
  input  logic                fifo_data_rx_ready_i,
  input  logic [SpiWordW-1:0] fifo_data_tx_i,
  input  logic                fifo_data_tx_valid_i,
  output logic                fifo_data_tx_ready_o,
  output logic                busy_o,
  output logic                cmd_err_o
);

  localparam int unsigned       TimerW    = $clog2(RespTimeout);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(RespTimeout - 1);
  localparam logic [1:0]        LastByte  = 2'(SpiWordBytes - 1);

  cmd_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;
  logic [7:0]        byte_q;
  logic              byte_vld_q;

  logic                addr_shift_in;
  logic                data_shift_in, data_shift_out, data_load;
  logic [SpiWordW-1:0] data_load_word, addr_word, data_word;
  logic                byte_take;

  // Incoming bytes are registered before the FSM consumes them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      timer_q    <= '0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      byte_q     <= rx_byte_i;
      byte_vld_q <= rx_byte_valid_i & ~csb_i;
    end
  end

  assign byte_take = byte_vld_q & ~csb_i;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    timer_d        = '0;
    rd_d           = rd_q;
    err_d          = 1'b0;
    addr_shift_in  = 1'b0;
    data_shift_in  = 1'b0;
    data_shift_out = 1'b0;
    data_load      = 1'b0;
    data_load_word = fifo_data_tx_i;
    unique case (state_q)
      StIdle: begin
        if (byte_take) begin
          if (byte_q == CmdRead || byte_q == CmdWrite) begin
            rd_d    = (byte_q == CmdRead);
            state_d = StAddr;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StAddr, StWdata: begin
        if (csb_i) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (byte_take) begin
          addr_shift_in = (state_q == StAddr);
          data_shift_in = (state_q == StWdata);
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == LastByte) begin
            state_d = (state_q == StAddr && !rd_q) ? StWdata : StIssue;
          end
        end
      end
      StIssue: state_d = rd_q ? StResp : StWpush;
      StWpush: begin
        if (fifo_data_rx_ready_i) state_d = StResp;
      end
      StResp: begin
        if (fifo_data_tx_valid_i) begin
          data_load = rd_q;
          state_d   = rd_q ? StRsend : StDone;
        end else if (timer_q == TimerLast) begin
          err_d          = 1'b1;
          data_load      = rd_q;
          data_load_word = TimeoutData;
          state_d        = rd_q ? StRsend : StDone;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRsend: begin
        if (csb_i) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (tx_byte_ready_i) begin
          data_shift_out = 1'b1;
          cnt_d          = cnt_q + 2'd1;
          if (cnt_q == LastByte) state_d = StDone;
        end
      end
      StDone: begin
        if (csb_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  spi_device_byte_shreg u_addr_shreg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (1'b0),
    .word_i      ('0),
    .shift_in_i  (addr_shift_in),
    .byte_i      (byte_q),
    .shift_out_i (1'b0),
    .word_o      (addr_word)
  );

  // Shared between write data (shifted in) and read data (loaded, shifted out).
  spi_device_byte_shreg u_data_shreg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (data_load),
    .word_i      (data_load_word),
    .shift_in_i  (data_shift_in),
    .byte_i      (byte_q),
    .shift_out_i (data_shift_out),
    .word_o      (data_word)
  );

  assign tx_byte_valid_o      = (state_q == StRsend);
  assign tx_byte_o            = tx_byte_valid_o ? data_word[SpiWordW-1 -: 8] : 8'h00;
  assign rxtx_addr_o          = addr_word;
  assign rxtx_addr_valid_o    = (state_q == StIssue);
  assign rd_wr_o              = rxtx_addr_valid_o & rd_q;
  assign fifo_data_rx_o       = data_word;
  assign fifo_data_rx_valid_o = (state_q == StWpush);
  assign fifo_data_tx_ready_o = 1'b1;
  assign busy_o               = (state_q != StIdle) && (state_q != StDone);
  assign cmd_err_o            = err_q;

endmodule
